// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with shadow buffer,
// decimal points, leading-zero blanking and a dark slot at each digit switch.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0]   r_dpb;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_cath;
  logic                    r_dp;

  logic                    w_last;
  logic [3:0]              w_code;
  logic                    w_dpsel;
  logic                    w_zero;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;

  assign w_last = (r_cnt == CMAX);

  // w_run tracks "this digit and every digit above it are zero"
  always_comb begin
    w_code  = 4'd0;
    w_dpsel = 1'b0;
    w_zero  = 1'b0;
    w_run   = 1'b1;
    w_an    = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run = w_run & (r_dig[4*k +: 4] == 4'd0);
      if (r_idx == IW'(k)) begin
        w_code  = r_dig[4*k +: 4];
        w_dpsel = r_dpb[k];
        w_zero  = w_run && (k != 0);
        w_an[k] = 1'b0;
      end
    end
    if (blank_in || w_last)
      w_an = '1;
  end

  always_comb begin
    w_seg = 7'b1111111;
    unique case (w_code)
      4'd0:  w_seg = 7'b0000001;
      4'd1:  w_seg = 7'b1001111;
      4'd2:  w_seg = 7'b0010010;
      4'd3:  w_seg = 7'b0000110;
      4'd4:  w_seg = 7'b1001100;
      4'd5:  w_seg = 7'b0100100;
      4'd6:  w_seg = 7'b0100000;
      4'd7:  w_seg = 7'b0001111;
      4'd8:  w_seg = 7'b0000000;
      4'd9:  w_seg = 7'b0000100;
      4'd10: w_seg = 7'b0001000;
      4'd11: w_seg = 7'b1100000;
      4'd12: w_seg = 7'b0110001;
      4'd13: w_seg = 7'b1000010;
      4'd14: w_seg = 7'b0110000;
      4'd15: w_seg = 7'b1111110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_dig  <= '0;
      r_dpb  <= '0;
      r_an   <= '1;
      r_cath <= 7'b1111111;
      r_dp   <= 1'b1;
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last)
        r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_dig <= digits_in;
        r_dpb <= dp_in;
      end
      r_an   <= w_an;
      r_cath <= (LZ_BLANK && w_zero) ? 7'b1111111 : w_seg;
      r_dp   <= ~w_dpsel;
    end
  end

  assign anode   = r_an;
  assign cathode = r_cath;
  assign dp      = r_dp;

endmodule
